maxnet_controller: RTL and testbench

// - Sequencer for the 4-node MaxNet datapath. Steps the shared FP multiply-accumulate unit

---
 rtl/maxnet_pkg.sv | 22 ++
 rtl/maxnet_winner_detect.sv | 33 +++
 rtl/maxnet_controller.sv | 115 +++++++++++
 tb/tb_maxnet_controller.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maxnet_pkg.sv
// Shared constants for the MaxNet controller and datapath.
package maxnet_pkg;

    localparam int unsigned N_DEFAULT        = 4;
    localparam int unsigned MAX_ITER_DEFAULT = 64;

    // Sequencer state encoding (kept as plain constants for legacy tools)
    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_LOAD     = 4'd1;
    localparam logic [3:0] S_CLR      = 4'd2;
    localparam logic [3:0] S_ISSUE    = 4'd3;
    localparam logic [3:0] S_MAC_WAIT = 4'd4;
    localparam logic [3:0] S_WRITE    = 4'd5;
    localparam logic [3:0] S_COMMIT   = 4'd6;
    localparam logic [3:0] S_CHECK    = 4'd7;
    localparam logic [3:0] S_DONE     = 4'd8;

    // IEEE-754 single weights used by the weight buffer: 1.0 and -0.2
    localparam logic [31:0] ONE     = 32'h3F800000;
    localparam logic [31:0] NEG_EPS = 32'hBE4CCCCD;

endpackage

// File: rtl/maxnet_winner_detect.sv
// Survivor analysis of the per-node "activation > 0" flags.
module maxnet_winner_detect
    import maxnet_pkg::*;
#(
    parameter int unsigned N  = N_DEFAULT,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  act_nz,
    output logic          le_one,
    output logic          exactly_one,
    output logic [IW-1:0] lowest
);

    logic [IW:0] cnt;
    logic        found;

    // Popcount plus lowest-index priority encode (0 when no bit set)
    always_comb begin
        cnt    = '0;
        found  = 1'b0;
        lowest = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cnt = cnt + {{IW{1'b0}}, act_nz[i]};
            if (act_nz[i] && !found) begin
                lowest = IW'(i);
                found  = 1'b1;
            end
        end
        le_one      = (cnt <= (IW+1)'(1));
        exactly_one = (cnt == (IW+1)'(1));
    end

endmodule

// File: rtl/maxnet_controller.sv
// Sequencer stepping the shared MAC through W*a, ReLU write-back and commit
// for each MaxNet iteration, then testing for a single survivor.
module maxnet_controller
    import maxnet_pkg::*;
#(
    parameter int unsigned N        = N_DEFAULT,
    parameter int unsigned MAX_ITER = MAX_ITER_DEFAULT,
    parameter int unsigned IW       = $clog2(N),
    parameter int unsigned WW       = $clog2(N*N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          mac_done,
    input  logic [N-1:0]  act_nz,
    output logic          ld_in,
    output logic          acc_clr,
    output logic          mac_start,
    output logic [WW-1:0] w_sel,
    output logic [IW-1:0] a_sel,
    output logic [N-1:0]  row_wr,
    output logic          commit,
    output logic          busy,
    output logic          done,
    output logic [IW-1:0] winner,
    output logic          win_valid,
    output logic          timeout,
    output logic [7:0]    iter_cnt
);

    localparam logic [IW-1:0] LAST = IW'(N-1);

    logic [3:0]    state, nxt;
    logic [IW-1:0] row, col;
    logic          le_one, exactly_one;
    logic [IW-1:0] lowest;

    maxnet_winner_detect #(.N(N), .IW(IW)) u_detect (
        .act_nz      (act_nz),
        .le_one      (le_one),
        .exactly_one (exactly_one),
        .lowest      (lowest)
    );

    // Next-state selection; mac_done only advances out of MAC_WAIT
    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:     if (start) nxt = S_LOAD;
            S_LOAD:     nxt = S_CLR;
            S_CLR:      nxt = S_ISSUE;
            S_ISSUE:    nxt = S_MAC_WAIT;
            S_MAC_WAIT: if (mac_done) nxt = (col == LAST) ? S_WRITE : S_ISSUE;
            S_WRITE:    nxt = (row == LAST) ? S_COMMIT : S_CLR;
            S_COMMIT:   nxt = S_CHECK;
            S_CHECK:    nxt = (le_one || iter_cnt == 8'(MAX_ITER)) ? S_DONE : S_CLR;
            S_DONE:     if (start) nxt = S_LOAD;
            default:    nxt = S_IDLE;
        endcase
    end

    // State, row/col/iteration counters and finish-result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            row       <= '0;
            col       <= '0;
            iter_cnt  <= '0;
            winner    <= '0;
            win_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state <= nxt;
            case (state)
                S_LOAD: begin
                    row       <= '0;
                    col       <= '0;
                    iter_cnt  <= '0;
                    win_valid <= 1'b0;
                    timeout   <= 1'b0;
                end
                S_CLR:      col <= '0;
                S_MAC_WAIT: if (mac_done && col != LAST) col <= col + 1'b1;
                S_WRITE:    if (row != LAST) row <= row + 1'b1;
                S_COMMIT: begin
                    row <= '0;
                    if (iter_cnt != 8'hFF) iter_cnt <= iter_cnt + 8'd1;
                end
                S_CHECK: begin
                    if (nxt == S_DONE) begin
                        winner    <= lowest;
                        win_valid <= exactly_one;
                        timeout   <= !le_one;
                    end
                end
                default: ;
            endcase
        end
    end

    // Pulses decoded from state; operand selects follow row/col directly
    always_comb begin
        ld_in     = (state == S_LOAD);
        acc_clr   = (state == S_CLR);
        mac_start = (state == S_ISSUE);
        commit    = (state == S_COMMIT);
        done      = (state == S_DONE);
        busy      = (state != S_IDLE) && (state != S_DONE);
        row_wr    = '0;
        if (state == S_WRITE) row_wr[row] = 1'b1;
        w_sel     = {row, col};
        a_sel     = col;
    end

endmodule

// File: tb/tb_maxnet_controller.sv
// Bench for maxnet_controller: behavioural datapath/MAC around the DUT and an
// independent MaxNet reference computed directly from the iteration rule.
module tb_maxnet_controller;

    logic       clk = 1'b0;
    logic       rst_n, start, mac_done;
    logic [3:0] act_nz;
    logic       ld_in, acc_clr, mac_start, commit, busy, done, win_valid, timeout;
    logic [3:0] w_sel, row_wr;
    logic [1:0] a_sel, winner;
    logic [7:0] iter_cnt;

    logic       start2, mac_done2;
    logic [3:0] act_nz2;
    logic       ld_in2, acc_clr2, mac_start2, commit2, busy2, done2, win_valid2, timeout2;
    logic [3:0] w_sel2, row_wr2;
    logic [1:0] a_sel2, winner2;
    logic [7:0] iter_cnt2;

    maxnet_controller #(.N(4), .MAX_ITER(64)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mac_done(mac_done), .act_nz(act_nz),
        .ld_in(ld_in), .acc_clr(acc_clr), .mac_start(mac_start), .w_sel(w_sel),
        .a_sel(a_sel), .row_wr(row_wr), .commit(commit), .busy(busy), .done(done),
        .winner(winner), .win_valid(win_valid), .timeout(timeout), .iter_cnt(iter_cnt)
    );

    maxnet_controller #(.N(4), .MAX_ITER(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .mac_done(mac_done2), .act_nz(act_nz2),
        .ld_in(ld_in2), .acc_clr(acc_clr2), .mac_start(mac_start2), .w_sel(w_sel2),
        .a_sel(a_sel2), .row_wr(row_wr2), .commit(commit2), .busy(busy2), .done(done2),
        .winner(winner2), .win_valid(win_valid2), .timeout(timeout2), .iter_cnt(iter_cnt2)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // datapath / MAC model state
    real         in_val[4];
    real         a_m[4];
    real         a_nxt[4];
    real         acc;
    int unsigned lat;
    int          md_cnt;
    logic [3:0]  cap_w;
    logic [1:0]  cap_a;
    bit          force_en, spurious, stall_chk;
    logic [3:0]  force_val;
    int          cyc;
    int          ld_cnt;
    int          ms_at_c1;
    int          commit_cyc[$];
    logic [3:0]  wlog[$];
    logic [1:0]  alog[$];
    logic [3:0]  rwlog[$];

    // reference results
    int unsigned ref_iter, ref_win;
    bit          ref_valid, ref_to;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic real wt(input int r, input int c);
        return (r == c) ? 1.0 : -0.2;
    endfunction

    function automatic logic [27:0] outs();
        return {ld_in, acc_clr, mac_start, w_sel, a_sel, row_wr, commit, busy, done,
                winner, win_valid, timeout, iter_cnt};
    endfunction

    // one clock: outputs seen this cycle act on the datapath model at the edge
    task automatic tick();
        logic       p_ld, p_clr, p_ms, p_cm, p_ms2;
        logic [3:0] p_rw, p_w;
        logic [1:0] p_a;
        p_ld = ld_in; p_clr = acc_clr; p_ms = mac_start; p_cm = commit;
        p_rw = row_wr; p_w = w_sel; p_a = a_sel; p_ms2 = mac_start2;
        @(posedge clk);
        #1;
        cyc++;
        if (!rst_n) begin
            md_cnt    = 0;
            mac_done  = 1'b0;
            mac_done2 = 1'b0;
        end else begin
            mac_done2 = p_ms2;
            if (p_ld) begin
                for (int i = 0; i < 4; i++) a_m[i] = in_val[i];
                ld_cnt++;
            end
            if (p_clr) acc = 0.0;
            for (int r = 0; r < 4; r++)
                if (p_rw[r]) a_nxt[r] = (acc > 0.0) ? acc : 0.0;
            if (p_rw != 4'b0) rwlog.push_back(p_rw);
            if (p_cm) begin
                for (int i = 0; i < 4; i++) a_m[i] = a_nxt[i];
                commit_cyc.push_back(cyc);
                if (commit_cyc.size() == 1) ms_at_c1 = wlog.size();
            end
            if (p_ms) begin
                cap_w  = p_w;
                cap_a  = p_a;
                md_cnt = int'(lat);
                wlog.push_back(p_w);
                alog.push_back(p_a);
            end
            mac_done = 1'b0;
            if (md_cnt > 0) begin
                if (stall_chk) check("sel_stable", 32'({w_sel, a_sel}), 32'({cap_w, cap_a}));
                md_cnt--;
                if (md_cnt == 0) begin
                    mac_done = 1'b1;
                    acc += wt(int'(cap_w[3:2]), int'(cap_w[1:0])) * a_m[cap_a];
                end
            end
            if (spurious && mac_start) mac_done = 1'b1;
        end
        for (int i = 0; i < 4; i++) act_nz[i] = force_en ? force_val[i] : (a_m[i] > 0.0);
    endtask

    task automatic run_case(input int unsigned l, input int unsigned budget,
                            input bit mid_start, input bit abort, output bit ok);
        lat = l; ld_cnt = 0; md_cnt = 0; ok = 1'b0; ms_at_c1 = -1;
        commit_cyc.delete(); wlog.delete(); alog.delete(); rwlog.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("load_done_low", 32'({done, busy}), 32'(2'b01));
        for (int unsigned k = 0; k < budget; k++) begin
            tick();
            if (mid_start && k == 60) begin
                start = 1'b1;
                tick();
                start = 1'b0;
            end
            if (abort && rwlog.size() == 2 && md_cnt > 0) begin
                rst_n = 1'b0;
                tick();
                check("rst_all_zero", 32'(outs()), 32'd0);
                rst_n = 1'b1;
                tick();
                check("rst_stays_idle", 32'({busy, done, ld_in}), 32'd0);
                ok = 1'b1;
                return;
            end
            if (done) begin
                ok = 1'b1;
                return;
            end
        end
        check("run_budget", 32'(done), 32'd1);
    endtask

    // MaxNet iterated straight from the rule a' = ReLU(W a)
    task automatic ref_model(input int unsigned max_iter);
        real a[4];
        real nx[4];
        real s;
        int  pos, first;
        for (int i = 0; i < 4; i++) a[i] = in_val[i];
        ref_iter = 0;
        for (int it = 0; it < 256; it++) begin
            for (int r = 0; r < 4; r++) begin
                s = 0.0;
                for (int c = 0; c < 4; c++) s += wt(r, c) * a[c];
                nx[r] = (s > 0.0) ? s : 0.0;
            end
            for (int i = 0; i < 4; i++) a[i] = nx[i];
            ref_iter++;
            pos = 0; first = -1;
            for (int i = 0; i < 4; i++)
                if (a[i] > 0.0) begin
                    pos++;
                    if (first < 0) first = i;
                end
            ref_win = (first < 0) ? 0 : first;
            if (pos <= 1) begin
                ref_valid = (pos == 1);
                ref_to    = 1'b0;
                break;
            end
            if (ref_iter == max_iter) begin
                ref_valid = 1'b0;
                ref_to    = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_ref(input string tag);
        ref_model(64);
        check({tag, "_done"},    32'(done),      32'd1);
        check({tag, "_iter"},    32'(iter_cnt),  32'(ref_iter));
        check({tag, "_winner"},  32'(winner),    32'(ref_win));
        check({tag, "_valid"},   32'(win_valid), 32'(ref_valid));
        check({tag, "_timeout"}, 32'(timeout),   32'(ref_to));
    endtask

    initial begin
        bit ok;
        rst_n = 1'b0; start = 1'b0; start2 = 1'b0; mac_done = 1'b0; mac_done2 = 1'b0;
        act_nz = 4'b0; act_nz2 = 4'b1111;
        force_en = 1'b0; force_val = 4'b0; spurious = 1'b0; stall_chk = 1'b0;
        cyc = 0; acc = 0.0; lat = 1; md_cnt = 0;
        for (int i = 0; i < 4; i++) begin a_m[i] = 0.0; a_nxt[i] = 0.0; in_val[i] = 0.0; end
        tick();
        tick();
        check("reset_outs", 32'(outs()), 32'd0);
        rst_n = 1'b1;
        tick();

        // reference example, with a stray start mid-run
        in_val = '{0.5, 0.9, 0.3, 0.7};
        run_case(1, 20000, 1'b1, 1'b0, ok);
        check_ref("ex");
        check("ex_winner_fixed", 32'(winner), 32'd1);
        check("ex_valid_fixed",  32'(win_valid), 32'd1);
        check("ex_single_load",  32'(ld_cnt), 32'd1);
        check("seq_len", 32'(wlog.size() >= 16 && rwlog.size() >= 4), 32'd1);
        for (int k = 0; k < 16 && k < wlog.size(); k++) begin
            check("seq_w_sel", 32'(wlog[k]), 32'(k));
            check("seq_a_sel", 32'(alog[k]), 32'(k % 4));
        end
        for (int k = 0; k < 4 && k < rwlog.size(); k++)
            check("seq_row_wr", 32'(rwlog[k]), 32'(1 << k));
        check("seq_ms_before_commit", 32'(ms_at_c1), 32'd16);
        check("commit_count", 32'(commit_cyc.size()), 32'(ref_iter));
        for (int k = 1; k < commit_cyc.size(); k++)
            check("commit_gap", 32'(commit_cyc[k] - commit_cyc[k-1]), 32'd42);

        // mac_done raised during ISSUE must not advance the sequencer
        spurious = 1'b1;
        run_case(1, 20000, 1'b0, 1'b0, ok);
        spurious = 1'b0;
        check_ref("spur");
        for (int k = 1; k < commit_cyc.size(); k++)
            check("spur_commit_gap", 32'(commit_cyc[k] - commit_cyc[k-1]), 32'd42);

        // single survivor and zero survivors at the first CHECK
        force_en = 1'b1; force_val = 4'b0100;
        run_case(1, 20000, 1'b0, 1'b0, ok);
        check("one_iter",    32'(iter_cnt),  32'd1);
        check("one_winner",  32'(winner),    32'd2);
        check("one_valid",   32'(win_valid), 32'd1);
        check("one_timeout", 32'(timeout),   32'd0);
        force_val = 4'b0000;
        run_case(1, 20000, 1'b0, 1'b0, ok);
        check("zero_iter",    32'(iter_cnt),  32'd1);
        check("zero_winner",  32'(winner),    32'd0);
        check("zero_valid",   32'(win_valid), 32'd0);
        check("zero_timeout", 32'(timeout),   32'd0);
        force_en = 1'b0;

        // iteration cap on the MAX_ITER=3 instance
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int k = 0; k < 2000 && !done2; k++) tick();
        check("cap_done",    32'(done2),      32'd1);
        check("cap_timeout", 32'(timeout2),   32'd1);
        check("cap_iter",    32'(iter_cnt2),  32'd3);
        check("cap_valid",   32'(win_valid2), 32'd0);

        // reset in MAC_WAIT of row 2, then a clean run
        in_val = '{0.8, 0.2, 0.6, 0.1};
        run_case(3, 20000, 1'b0, 1'b1, ok);
        check("abort_reached", 32'(ok), 32'd1);
        run_case(1, 20000, 1'b0, 1'b0, ok);
        check_ref("after_rst");
        check("after_rst_load", 32'(ld_cnt), 32'd1);

        // long MAC latency with select stability checked every wait cycle
        stall_chk = 1'b1;
        in_val = '{0.4, 0.35, 0.9, 0.6};
        run_case(5, 40000, 1'b0, 1'b0, ok);
        stall_chk = 1'b0;
        check_ref("stall");

        // randomized activations and MAC latency
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 4; i++) in_val[i] = real'($urandom_range(1, 1000)) / 1000.0;
            run_case($urandom_range(1, 3), 40000, 1'b0, 1'b0, ok);
            check_ref("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
